// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a shared asynchronous SRAM.
// Each grant runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> ACK with registered strobes.
module sram_arbiter #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_Dout,
  output logic              Mem_Drive,
  input  logic [DATA_W-1:0] Mem_Din,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StAck} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_dbg_q, last_dbg_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              wen_q, wen_d;
  logic              drive_q, drive_d;
  logic              grant_dbg;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dbg_d  = last_dbg_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    // On a tie the port that lost the previous grant wins.
    grant_dbg   = dbg_req && (!cpu_req || !last_dbg_q);

    unique case (state_q)
      StIdle: begin
        if (cpu_req || dbg_req) begin
          owner_d    = grant_dbg;
          last_dbg_d = grant_dbg;
          we_d       = grant_dbg ? dbg_we    : cpu_we;
          addr_d     = grant_dbg ? dbg_addr  : cpu_addr;
          wdata_d    = grant_dbg ? dbg_wdata : cpu_wdata;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = CntW'(WAIT_CYCLES - 1);
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q) dbg_rdata_d = Mem_Din;
            else         cpu_rdata_d = Mem_Din;
          end
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are registered from the next state so they change cleanly at each edge.
    ce_d    = (state_d != StIdle);
    oe_d    = !((state_d == StAccess) && !we_d);
    wen_d   = !((state_d == StAccess) && we_d);
    drive_d = (state_d != StIdle) && we_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_dbg_q  <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      ce_q        <= 1'b0;
      oe_q        <= 1'b1;
      wen_q       <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dbg_q  <= last_dbg_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      ce_q        <= ce_d;
      oe_q        <= oe_d;
      wen_q       <= wen_d;
      drive_q     <= drive_d;
    end
  end

  // ce_q is the active-high "chip selected" flag; the pins are active-low.
  assign Mem_CE    = !ce_q;
  assign Mem_UB    = !ce_q;
  assign Mem_LB    = !ce_q;
  assign Mem_OE    = oe_q;
  assign Mem_WE    = wen_q;
  assign Mem_ADDR  = addr_q;
  assign Mem_Dout  = wdata_q;
  assign Mem_Drive = drive_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ack   = (state_q == StAck) && !owner_q;
  assign dbg_ack   = (state_q == StAck) && owner_q;
  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed plus randomized bench for sram_arbiter against an SRAM model and a
// transaction-level reference (expected memory contents, latency and strobe counts).
module tb_sram_arbiter;

  localparam int unsigned W = 3;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [19:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic        cpu_ack, dbg_ack;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive;
  logic [19:0] Mem_ADDR;
  logic [15:0] Mem_Dout, Mem_Din;
  logic        busy, owner;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] sram [65536];
  logic [15:0] exp_mem [logic [19:0]];
  logic [19:0] pool [$];
  logic [15:0] exp_cpu_rd, exp_dbg_rd;
  bit          model_last_dbg;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_ADDR(Mem_ADDR), .Mem_Dout(Mem_Dout), .Mem_Drive(Mem_Drive), .Mem_Din(Mem_Din),
    .busy(busy), .owner(owner)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (!Mem_CE && !Mem_WE && Mem_Drive) sram[Mem_ADDR[15:0]] <= Mem_Dout;
  end
  assign Mem_Din = (!Mem_CE && !Mem_OE) ? sram[Mem_ADDR[15:0]] : 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      check("inv_oe_we", {31'd0, !Mem_OE && !Mem_WE}, 32'd0);
      check("inv_drive_read", {31'd0, Mem_Drive && !Mem_OE}, 32'd0);
      check("inv_ack_overlap", {31'd0, cpu_ack && dbg_ack}, 32'd0);
    end
  end

  task automatic drive_port(input bit port, input bit req, input bit we,
                            input logic [19:0] addr, input logic [15:0] wdata);
    if (port) begin
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  // Call #1 after a rising edge with the arbiter idle; returns #1 after the
  // edge that re-enters IDLE.
  task automatic do_txn(input bit port, input bit we, input logic [19:0] addr,
                        input logic [15:0] wdata, input bit withdraw);
    int ack_n = 0, oe_n = 0, we_n = 0, drv_n = 0;
    int addr_bad = 0, busy_bad = 0, other_ack = 0;
    logic [15:0] cap_cpu = '0, cap_dbg = '0, exp_rd = '0;
    logic cap_owner = 1'b0;
    if (!we) exp_rd = exp_mem[addr];
    drive_port(port, 1'b1, we, addr, wdata);
    for (int n = 1; n <= int'(W) + 6 && ack_n == 0; n++) begin
      @(posedge Clk); #1;
      if (withdraw && n == 1) drive_port(port, 1'b0, !we, addr ^ 20'h00F0F, ~wdata);
      if (!Mem_OE) oe_n++;
      if (!Mem_WE) we_n++;
      if (Mem_Drive) drv_n++;
      if (!Mem_CE && Mem_ADDR !== addr) addr_bad++;
      if (!busy) busy_bad++;
      if (port ? cpu_ack : dbg_ack) other_ack++;
      if (port ? dbg_ack : cpu_ack) begin
        ack_n = n; cap_cpu = cpu_rdata; cap_dbg = dbg_rdata; cap_owner = owner;
        drive_port(port, 1'b0, we, addr, wdata);
      end
    end
    drive_port(port, 1'b0, we, addr, wdata);
    if (!we) begin
      if (port) exp_dbg_rd = exp_rd; else exp_cpu_rd = exp_rd;
    end else begin
      if (!exp_mem.exists(addr)) pool.push_back(addr);
      exp_mem[addr] = wdata;
    end
    model_last_dbg = port;
    check("txn_ack_cycle", ack_n, 2 + W);
    check("txn_oe_cycles", oe_n, we ? 0 : W);
    check("txn_we_cycles", we_n, we ? W : 0);
    check("txn_drive_cycles", drv_n, we ? W + 2 : 0);
    check("txn_addr_stable", addr_bad, 0);
    check("txn_busy", busy_bad, 0);
    check("txn_other_ack", other_ack, 0);
    check("txn_owner", {31'd0, cap_owner}, {31'd0, port});
    check("txn_cpu_rdata", cap_cpu, exp_cpu_rd);
    check("txn_dbg_rdata", cap_dbg, exp_dbg_rd);
    @(posedge Clk); #1;
    check("txn_idle_after", {busy, Mem_CE, Mem_Drive, cpu_ack, dbg_ack}, 5'b01000);
  endtask

  initial begin
    int ack_cnt, last_ack, overlap;
    bit exp_port;
    logic [19:0] a;
    logic [15:0] d;
    bit p, w;
    int bad;

    Reset_n = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    exp_cpu_rd = '0; exp_dbg_rd = '0; model_last_dbg = 1'b1;
    #12;
    check("rst_flags", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive, cpu_ack, dbg_ack,
                        busy, owner}, 10'b1111100000);
    check("rst_addr", Mem_ADDR, 0);
    check("rst_dout", Mem_Dout, 0);
    check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    @(negedge Clk); Reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive, cpu_ack, dbg_ack, busy}
          !== 9'b111110000 || Mem_ADDR !== '0) bad++;
    end
    check("idle_10_cycles", bad, 0);

    // Contention right after reset: CPU wins the first tie, then strict alternation.
    drive_port(1'b0, 1'b1, 1'b1, 20'h00400, 16'hC0DE);
    drive_port(1'b1, 1'b1, 1'b1, 20'h00500, 16'hD00D);
    ack_cnt = 0; last_ack = 0; overlap = 0; exp_port = !model_last_dbg;
    for (int n = 1; n <= 4 * (3 + int'(W)) + 4 && ack_cnt < 4; n++) begin
      @(posedge Clk); #1;
      if (cpu_ack && dbg_ack) overlap++;
      if (cpu_ack || dbg_ack) begin
        check("cont_winner", {31'd0, dbg_ack}, {31'd0, exp_port});
        check("cont_spacing", n - last_ack, ack_cnt == 0 ? 2 + W : 3 + W);
        last_ack = n; ack_cnt++; exp_port = !exp_port;
        if (ack_cnt == 4) begin
          cpu_req = 1'b0; dbg_req = 1'b0;
        end
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("cont_ack_count", ack_cnt, 4);
    check("cont_overlap", overlap, 0);
    model_last_dbg = !exp_port;
    exp_mem[20'h00400] = 16'hC0DE; pool.push_back(20'h00400);
    exp_mem[20'h00500] = 16'hD00D; pool.push_back(20'h00500);
    check("cont_sram_cpu", sram[16'h0400], 16'hC0DE);
    check("cont_sram_dbg", sram[16'h0500], 16'hD00D);
    @(posedge Clk); #1;
    check("cont_idle", {31'd0, busy}, 32'd0);

    do_txn(1'b1, 1'b1, 20'h0FFFF, 16'h1234, 1'b0);
    check("dbg_write_mem", sram[16'hFFFF], 16'h1234);
    do_txn(1'b1, 1'b1, 20'h00123, 16'hBEEF, 1'b0);
    do_txn(1'b0, 1'b0, 20'h00123, 16'h0000, 1'b0);
    check("cpu_read_beef", cpu_rdata, 16'hBEEF);
    do_txn(1'b0, 1'b0, 20'h0FFFF, 16'h0000, 1'b1);
    check("withdraw_rdata", cpu_rdata, 16'h1234);
    do_txn(1'b1, 1'b0, 20'h00400, 16'h0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom());
      if (w && $urandom_range(0, 1) == 0) a = 20'($urandom_range(0, 65535));
      else a = pool[$urandom_range(0, pool.size() - 1)];
      do_txn(p, w, a, d, 1'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a debug write.
    drive_port(1'b1, 1'b1, 1'b1, 20'h0AAAA, 16'h5555);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("midrst_in_access", {31'd0, Mem_WE}, 32'd0);
    Reset_n = 1'b0;
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    check("midrst_strobes", {Mem_WE, Mem_CE, Mem_OE, Mem_Drive, dbg_ack, cpu_ack, busy, owner},
          8'b11100000);
    check("midrst_rdata", {cpu_rdata, dbg_rdata}, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      if (!Mem_WE || !Mem_CE || Mem_Drive || cpu_ack || dbg_ack) bad++;
    end
    check("midrst_quiet", bad, 0);
    @(negedge Clk); Reset_n = 1'b1;
    exp_cpu_rd = '0; exp_dbg_rd = '0; model_last_dbg = 1'b1;
    @(posedge Clk); #1;
    do_txn(1'b0, 1'b0, 20'h00123, 16'h0000, 1'b0);
    do_txn(1'b1, 1'b1, 20'h00777, 16'hA5A5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
